// File: rtl/bit_serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder: FSM state codes and the
// signed-overflow rule applied at the MSB.
package bit_serial_adder_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Signed overflow: carry into the MSB disagrees with carry out of it.
   function automatic logic signed_ovf(input logic carry_into_msb, input logic carry_out);
      return carry_into_msb ^ carry_out;
   endfunction

endpackage

// File: rtl/bit_serial_adder_full_adder.sv
// One-bit full adder cell; the serial adder reuses a single instance each cycle.
module bit_serial_adder_full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic c
);

   assign s = a ^ b ^ cin;
   assign c = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/bit_serial_adder.sv
// WIDTH-bit adder that processes one bit per clock, LSB first, through one full
// adder cell with a registered carry; result is held until the next accepted start.
module bit_serial_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   import bit_serial_adder_pkg::*;

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_PENULT = CW'(WIDTH - 2);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] sh_a_reg, sh_b_reg, sh_s_reg, sum_reg;
   logic [CW-1:0]    count_reg;
   logic             carry_reg, msb_cin_reg, cout_reg, ovf_reg;
   logic             fa_s, fa_c;

   bit_serial_adder_full_adder u_cell (
      .a   (sh_a_reg[0]),
      .b   (sh_b_reg[0]),
      .cin (carry_reg),
      .s   (fa_s),
      .c   (fa_c)
   );

   always_ff @(posedge clk) begin
      if (reset) state_reg <= S_IDLE;
      else       state_reg <= state_next;
   end

   // Handshake outputs depend on the state register only.
   always_comb begin
      state_next = state_reg;
      ready      = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         S_IDLE: begin
            ready = 1'b1;
            if (start) state_next = S_RUN;
         end
         S_RUN: begin
            busy = 1'b1;
            if (count_reg == CNT_LAST) state_next = S_DONE;
         end
         S_DONE: begin
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sh_a_reg    <= '0;
         sh_b_reg    <= '0;
         sh_s_reg    <= '0;
         sum_reg     <= '0;
         count_reg   <= '0;
         carry_reg   <= 1'b0;
         msb_cin_reg <= 1'b0;
         cout_reg    <= 1'b0;
         ovf_reg     <= 1'b0;
      end else if (state_reg == S_IDLE) begin
         if (start) begin
            sh_a_reg  <= a;
            sh_b_reg  <= b;
            carry_reg <= cin;
            count_reg <= '0;
         end
      end else if (state_reg == S_RUN) begin
         sh_a_reg  <= sh_a_reg >> 1;
         sh_b_reg  <= sh_b_reg >> 1;
         sh_s_reg  <= {fa_s, sh_s_reg[WIDTH-1:1]};
         carry_reg <= fa_c;
         if (count_reg == CNT_PENULT) msb_cin_reg <= fa_c;
         // Counter stops at the last bit so it never wraps.
         if (count_reg == CNT_LAST) begin
            sum_reg  <= {fa_s, sh_s_reg[WIDTH-1:1]};
            cout_reg <= fa_c;
            ovf_reg  <= signed_ovf(msb_cin_reg, fa_c);
         end else begin
            count_reg <= count_reg + 1'b1;
         end
      end
   end

   assign sum  = sum_reg;
   assign cout = cout_reg;
   assign ovf  = ovf_reg;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder (WIDTH=16): directed corner cases,
// ignored starts, reset abort and a randomized back-to-back regression.
module tb_bit_serial_adder;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         reset, start, cin;
   logic [W-1:0] a, b;
   logic         ready, busy, done, cout, ovf;
   logic [W-1:0] sum;

   int tests_run    = 0;
   int tests_failed = 0;

   bit_serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain integer arithmetic, signed overflow by range check.
   task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                        output logic [W-1:0] s, output logic co, output logic ov);
      int unsigned u;
      int          sg;
      u  = int'(x) + int'(y) + int'(ci);
      s  = u[W-1:0];
      co = u[W];
      sg = int'($signed(x)) + int'($signed(y)) + int'(ci);
      ov = (sg > 32767) || (sg < -32768);
   endtask

   // Called in a ready cycle; returns in the done cycle (or -1 on timeout).
   // Operands are scrambled right after the accepting edge.
   task automatic launch_and_wait(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic ci, output int done_cyc);
      a = x; b = y; cin = ci; start = 1'b1;
      tick();
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      done_cyc = -1;
      for (int k = 1; k <= 40; k++) begin
         if (done) begin
            done_cyc = k;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      tick(); tick();
      reset = 1'b0;
      tests_run++;
      if ({ready, busy, done} !== 3'b100) begin
         tests_failed++;
         $display("[TB] FAIL reset_ctrl: got rdy/busy/done=%b, want 100", {ready, busy, done});
      end
      tests_run++;
      if ({sum, cout, ovf} !== {16'h0000, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("[TB] FAIL reset_result: got sum=%h cout=%b ovf=%b, want 0 0 0", sum, cout, ovf);
      end
   endtask

   task automatic test_directed();
      logic [W-1:0] va [5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'hFFFF, 16'h8000};
      logic [W-1:0] vb [5] = '{16'h4321, 16'h0001, 16'h0001, 16'hFFFF, 16'h8000};
      logic         vc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [W-1:0] es [5] = '{16'h5555, 16'h0000, 16'h8000, 16'hFFFF, 16'h0000};
      logic         eco[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      logic         eov[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      int           dc;
      for (int i = 0; i < 5; i++) begin
         launch_and_wait(va[i], vb[i], vc[i], dc);
         $display("[TB] directed %0d: %h + %h + %0d -> sum=%h cout=%0d ovf=%0d done@%0d",
                  i, va[i], vb[i], vc[i], sum, cout, ovf, dc);
         tests_run++;
         if (dc !== 17) begin
            tests_failed++;
            $display("[TB] FAIL dir_latency[%0d]: done cycle %0d, want 17", i, dc);
         end
         tests_run++;
         if ({sum, cout, ovf} !== {es[i], eco[i], eov[i]}) begin
            tests_failed++;
            $display("[TB] FAIL dir_result[%0d]: got %h/%b/%b, want %h/%b/%b",
                     i, sum, cout, ovf, es[i], eco[i], eov[i]);
         end
         tick();
         tests_run++;
         if ({ready, sum} !== {1'b1, es[i]}) begin
            tests_failed++;
            $display("[TB] FAIL dir_hold[%0d]: got ready=%b sum=%h, want 1 %h", i, ready, sum, es[i]);
         end
      end
   endtask

   task automatic test_ignored_start();
      int pulses = 0;
      a = 16'h0001; b = 16'h0001; cin = 1'b0; start = 1'b1;
      tick();
      for (int cyc = 1; cyc <= 35; cyc++) begin
         if (done) pulses++;
         if (cyc == 5) begin
            tests_run++;
            if (busy !== 1'b1) begin
               tests_failed++;
               $display("[TB] FAIL ign_busy: got busy=%b in cycle 5, want 1", busy);
            end
         end
         if (cyc == 17) begin
            $display("[TB] ignored-start op: 0001 + 0001 -> sum=%h done=%0d", sum, done);
            tests_run++;
            if ({done, sum} !== {1'b1, 16'h0002}) begin
               tests_failed++;
               $display("[TB] FAIL ign_first: got done=%b sum=%h, want 1 0002", done, sum);
            end
         end
         if (cyc == 18) begin
            tests_run++;
            if ({ready, sum} !== {1'b1, 16'h0002}) begin
               tests_failed++;
               $display("[TB] FAIL ign_idle: got ready=%b sum=%h, want 1 0002", ready, sum);
            end
         end
         if (cyc == 35) begin
            $display("[TB] accepted op: aaaa + 5555 -> sum=%h done=%0d", sum, done);
            tests_run++;
            if ({done, sum} !== {1'b1, 16'hFFFF}) begin
               tests_failed++;
               $display("[TB] FAIL ign_second: got done=%b sum=%h, want 1 ffff", done, sum);
            end
            break;
         end
         start = (cyc == 5) || (cyc == 17) || (cyc == 18);
         if (start) begin
            a = 16'hAAAA; b = 16'h5555; cin = 1'b0;
         end
         tick();
      end
      start = 1'b0;
      tests_run++;
      if (pulses !== 2) begin
         tests_failed++;
         $display("[TB] FAIL ign_pulses: got %0d done pulses, want 2", pulses);
      end
      tick();
   endtask

   task automatic test_reset_mid_run();
      int pulses = 0;
      a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int cyc = 1; cyc < 6; cyc++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      $display("[TB] reset mid-run: ready=%b busy=%b sum=%h", ready, busy, sum);
      tests_run++;
      if ({ready, busy, done, sum, cout, ovf} !== {3'b100, 16'h0000, 2'b00}) begin
         tests_failed++;
         $display("[TB] FAIL abort_state: got r/b/d=%b%b%b sum=%h cout=%b ovf=%b, want 100 0000 0 0",
                  ready, busy, done, sum, cout, ovf);
      end
      for (int k = 0; k < 25; k++) begin
         if (done) pulses++;
         tick();
      end
      tests_run++;
      if (pulses !== 0) begin
         tests_failed++;
         $display("[TB] FAIL abort_done: got %0d done pulses, want 0", pulses);
      end
      reset = 1'b1; start = 1'b1; a = 16'h0F0F; b = 16'h0101; cin = 1'b1;
      tick();
      reset = 1'b0; start = 1'b0;
      $display("[TB] reset+start: ready=%b busy=%b", ready, busy);
      tests_run++;
      if ({ready, busy} !== 2'b10) begin
         tests_failed++;
         $display("[TB] FAIL rst_start: got ready=%b busy=%b, want 1 0", ready, busy);
      end
      pulses = 0;
      for (int k = 0; k < 20; k++) begin
         if (done || busy) pulses++;
         tick();
      end
      tests_run++;
      if ({pulses, sum} !== {32'd0, 16'h0000}) begin
         tests_failed++;
         $display("[TB] FAIL rst_start_idle: got %0d active cycles sum=%h, want 0 0000", pulses, sum);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] x, y, es;
      logic         ci, eco, eov;
      int           dc;
      for (int n = 0; n < 1000; n++) begin
         x = W'($urandom); y = W'($urandom); ci = 1'($urandom);
         if (n % 10 == 0) x = {x[W-1], {(W-1){~x[W-1]}}};
         model(x, y, ci, es, eco, eov);
         launch_and_wait(x, y, ci, dc);
         $display("[TB] rand %0d: %h + %h + %0d -> sum=%h cout=%0d ovf=%0d", n, x, y, ci, sum, cout, ovf);
         tests_run++;
         if (dc !== 17 || {sum, cout, ovf} !== {es, eco, eov}) begin
            tests_failed++;
            $display("[TB] FAIL rand[%0d]: done@%0d %h/%b/%b, want done@17 %h/%b/%b",
                     n, dc, sum, cout, ovf, es, eco, eov);
         end
         tick();
         tests_run++;
         if (ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL rand_ready[%0d]: got ready=%b, want 1", n, ready);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_ignored_start();
      test_reset_mid_run();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
